spart_rx: RTL and testbench

- Serial receiver half of the SPART.
- Oversamples the asynchronous rxd line at 16 enables per bit and recovers 8N1 frames: start bit, 8 data bits LSB first, 1 stop bit.
- Presents the received byte to the processor bus with a receive-data-available (rda) flag, plus framing-error and overrun status.
- Shares the baud enable generator and the ioaddr/iorw bus decode with the transmitter.

---
 rtl/spart_pkg.sv | 22 ++
 rtl/rx_sync_edge.sv | 30 +++
 rtl/spart_rx.sv | 119 +++++++++++
 tb/tb_spart_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART constants, bus addresses and receiver state encoding
package spart_pkg;

    // Bus register map shared with the transmitter and baud generator
    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    // Frame timing in baud enables
    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;

endpackage

// File: rtl/rx_sync_edge.sv
// rtl/rx_sync_edge.sv - rxd metastability synchronizer and falling-edge detector
module rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs,
    output logic fall_edge
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Shift rxd through the synchronizer and keep one old sample for edge detection;
    // everything resets to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rxd};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rxs       = sync[SYNC_STAGES-1];
    assign fall_edge = prev & ~rxs;

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART 8N1 receiver with oversampled frame recovery and bus status
module spart_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    input  logic [1:0] ioaddr,
    input  logic       iorw,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err,
    output logic       overrun
);
    import spart_pkg::*;

    localparam int             CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  LAST_EN  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]  MID_EN   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_t   state;
    logic [CW-1:0] en_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic        rxs;
    logic        fall_edge;
    logic        rd;

    rx_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rxs      (rxs),
        .fall_edge(fall_edge)
    );

    assign rd = (ioaddr == ADDR_DATA) && iorw;

    // Frame FSM plus bus status; a store in STOP is written after the read-clear
    // so a coincident read loses to the new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            en_cnt      <= '0;
            bit_cnt     <= '0;
            shift       <= 8'h00;
            rx_data     <= 8'h00;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (rd) begin
                rda         <= 1'b0;
                overrun     <= 1'b0;
                framing_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fall_edge) begin
                        state  <= START;
                        en_cnt <= '0;
                    end
                end
                START: begin
                    if (enable) begin
                        if (en_cnt == MID_EN) begin
                            en_cnt <= '0;
                            if (!rxs) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            en_cnt <= en_cnt + CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (enable) begin
                        if (en_cnt == LAST_EN) begin
                            en_cnt  <= '0;
                            shift   <= {rxs, shift[7:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end
                        end else begin
                            en_cnt <= en_cnt + CW'(1);
                        end
                    end
                end
                STOP: begin
                    if (enable) begin
                        if (en_cnt == LAST_EN) begin
                            en_cnt      <= '0;
                            rx_data     <= shift;
                            framing_err <= ~rxs;
                            overrun     <= rda && !rd;
                            rda         <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            en_cnt <= en_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - directed self-checking bench for spart_rx
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rxd;
    logic [1:0] ioaddr;
    logic       iorw;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;

    int passed  = 0;
    int total   = 0;
    int tick_no = 0;
    int rda_tick = -1;
    int rd_tick  = -1;
    int en_div   = 1;
    int div_cnt  = 0;

    spart_rx #(
        .SYNC_STAGES(2),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rxd        (rxd),
        .ioaddr     (ioaddr),
        .iorw       (iorw),
        .rx_data    (rx_data),
        .rda        (rda),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        tick_no = tick_no + 1;
        if (rda === 1'b1 && rda_tick < 0) rda_tick = tick_no;
        enable  = (div_cnt == 0);
        div_cnt = (div_cnt + 1 >= en_div) ? 0 : div_cnt + 1;
        iorw    = (tick_no == rd_tick);
    endtask

    task automatic drive_bits(input logic val, input int n);
        int k = 0;
        while (k < n) begin
            tick();
            rxd = val;
            if (enable) k = k + 1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        tick_no  = -1;
        rda_tick = -1;
        drive_bits(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bits(b[i], 16);
        drive_bits(stop_bit, 16);
    endtask

    task automatic do_read();
        tick();
        ioaddr = 2'b00;
        iorw   = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; rxd = 1'b1; iorw = 1'b0; ioaddr = 2'b00; enable = 1'b0;
        tick(); tick();
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else passed++;
        total++;
        if (rda !== 1'b0) $display("FAIL reset_rda: got %b expected 0", rda); else passed++;
        total++;
        if (framing_err !== 1'b0) $display("FAIL reset_framing_err: got %b expected 0", framing_err); else passed++;
        total++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
        total++;
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            drive_bits(1'b1, 1);
            if (rx_data !== 8'h00 || rda !== 1'b0 || framing_err !== 1'b0 || overrun !== 1'b0) bad++;
        end
        if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad); else passed++;
        total++;
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1);
        if (rda_tick !== 155) $display("FAIL a5_latency: got tick %0d expected 155", rda_tick); else passed++;
        total++;
        if (rda !== 1'b1) $display("FAIL a5_rda: got %b expected 1", rda); else passed++;
        total++;
        if (rx_data !== 8'hA5) $display("FAIL a5_data: got %h expected a5", rx_data); else passed++;
        total++;
        if (framing_err !== 1'b0) $display("FAIL a5_fe: got %b expected 0", framing_err); else passed++;
        total++;
        do_read();
        if (rda !== 1'b0) $display("FAIL a5_read_rda: got %b expected 0", rda); else passed++;
        total++;
        if (rx_data !== 8'hA5) $display("FAIL a5_read_hold: got %h expected a5", rx_data); else passed++;
        total++;
    endtask

    task automatic test_glitch();
        drive_bits(1'b0, 4);
        drive_bits(1'b1, 40);
        if (rda !== 1'b0) $display("FAIL glitch_rda: got %b expected 0", rda); else passed++;
        total++;
        send_frame(8'h3C, 1'b1);
        if (rda !== 1'b1 || rx_data !== 8'h3C) $display("FAIL glitch_next: got rda %b data %h expected 1 3c", rda, rx_data); else passed++;
        total++;
        do_read();
        drive_bits(1'b1, 8);
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0);
        if (rda !== 1'b1 || rx_data !== 8'h3C) $display("FAIL fe_store: got rda %b data %h expected 1 3c", rda, rx_data); else passed++;
        total++;
        if (framing_err !== 1'b1) $display("FAIL fe_flag: got %b expected 1", framing_err); else passed++;
        total++;
        drive_bits(1'b0, 40);
        drive_bits(1'b1, 20);
        if (rx_data !== 8'h3C || framing_err !== 1'b1) $display("FAIL fe_low_hold: got data %h fe %b expected 3c 1", rx_data, framing_err); else passed++;
        total++;
        send_frame(8'h5A, 1'b1);
        if (rx_data !== 8'h5A) $display("FAIL fe_recover_data: got %h expected 5a", rx_data); else passed++;
        total++;
        if (framing_err !== 1'b0) $display("FAIL fe_recover_flag: got %b expected 0", framing_err); else passed++;
        total++;
        if (overrun !== 1'b1) $display("FAIL fe_recover_overrun: got %b expected 1", overrun); else passed++;
        total++;
        do_read();
        if (overrun !== 1'b0 || rda !== 1'b0) $display("FAIL read_clears: got ovr %b rda %b expected 0 0", overrun, rda); else passed++;
        total++;
        drive_bits(1'b1, 8);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        drive_bits(1'b1, 4);
        send_frame(8'h22, 1'b1);
        if (rx_data !== 8'h22) $display("FAIL ovr_data: got %h expected 22", rx_data); else passed++;
        total++;
        if (overrun !== 1'b1 || rda !== 1'b1) $display("FAIL ovr_flag: got ovr %b rda %b expected 1 1", overrun, rda); else passed++;
        total++;
        do_read();
        drive_bits(1'b1, 4);
        send_frame(8'h11, 1'b1);
        drive_bits(1'b1, 4);
        rd_tick = 154;
        send_frame(8'h22, 1'b1);
        rd_tick = -1;
        if (rda !== 1'b1 || rx_data !== 8'h22) $display("FAIL rdstore_data: got rda %b data %h expected 1 22", rda, rx_data); else passed++;
        total++;
        if (overrun !== 1'b0) $display("FAIL rdstore_overrun: got %b expected 0", overrun); else passed++;
        total++;
        drive_bits(1'b1, 4);
    endtask

    task automatic test_reset_mid();
        logic [7:0] v = 8'h77;
        drive_bits(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bits(v[i], 16);
        drive_bits(v[4], 6);
        rst = 1'b1;
        tick(); tick();
        if (rx_data !== 8'h00 || rda !== 1'b0 || framing_err !== 1'b0 || overrun !== 1'b0)
            $display("FAIL midreset_outputs: got %h %b %b %b expected 00 0 0 0", rx_data, rda, framing_err, overrun);
        else passed++;
        total++;
        rst = 1'b0;
        drive_bits(1'b1, 30);
        if (rda !== 1'b0) $display("FAIL midreset_quiet: got %b expected 0", rda); else passed++;
        total++;
        send_frame(8'h99, 1'b1);
        if (rda !== 1'b1 || rx_data !== 8'h99 || overrun !== 1'b0)
            $display("FAIL midreset_next: got rda %b data %h ovr %b expected 1 99 0", rda, rx_data, overrun);
        else passed++;
        total++;
        do_read();
    endtask

    task automatic test_slow_enable();
        en_div  = 3;
        div_cnt = 0;
        drive_bits(1'b1, 10);
        send_frame(8'hC3, 1'b1);
        if (rda !== 1'b1 || rx_data !== 8'hC3 || framing_err !== 1'b0)
            $display("FAIL slow_frame: got rda %b data %h fe %b expected 1 c3 0", rda, rx_data, framing_err);
        else passed++;
        total++;
        en_div  = 1;
        div_cnt = 0;
        do_read();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_mid();
        test_slow_enable();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
